// File: rtl/timer_pkg.sv
// timer_pkg: shared width, mode encoding and bus-slicing helper for multi_timeout
package timer_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/timeout_channel.sv
// timeout_channel: one down-counter with start-edge load, cancel, hold and optional auto-reload
module timeout_channel
  import timer_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         start,
  input  logic         cancel,
  input  logic         hold,
  input  logic         periodic,
  input  logic [W-1:0] value,
  output logic [W-1:0] counter,
  output logic         expired
);
  logic         start_latch;
  logic         mode;
  logic [W-1:0] reload;
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      counter     <= '0;
      reload      <= '0;
      mode        <= MODE_ONESHOT;
      start_latch <= 1'b0;
      expired     <= 1'b0;
    end else begin
      start_latch <= start;
      expired     <= 1'b0;
      if (cancel) counter <= '0;
      else if (start && !start_latch) begin
        counter <= value;
        reload  <= value;
        mode    <= periodic;
      end else if (!hold && counter == W'(1)) begin
        counter <= (mode == MODE_PERIODIC) ? reload : '0;
        expired <= 1'b1;
      end else if (!hold && counter != '0) counter <= counter - W'(1);
    end
  end
endmodule

// File: rtl/multi_timeout.sv
// multi_timeout: CHANNELS independent timeout channels with packed value/counter buses
module multi_timeout
  import timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_WIDTH,
  parameter int CHANNELS = 4
) (
  input  logic                              clk_in,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               start,
  input  logic [CHANNELS-1:0]               cancel,
  input  logic [CHANNELS-1:0]               hold,
  input  logic [CHANNELS-1:0]               periodic,
  input  logic [CHANNELS*COUNTER_WIDTH-1:0] value,
  output logic [CHANNELS*COUNTER_WIDTH-1:0] counter,
  output logic [CHANNELS-1:0]               running,
  output logic [CHANNELS-1:0]               expired,
  output logic                              any_running
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    timeout_channel #(.W(COUNTER_WIDTH)) u_ch (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .start   (start[c]),
      .cancel  (cancel[c]),
      .hold    (hold[c]),
      .periodic(periodic[c]),
      .value   (value[slice_lo(c, COUNTER_WIDTH) +: COUNTER_WIDTH]),
      .counter (counter[slice_lo(c, COUNTER_WIDTH) +: COUNTER_WIDTH]),
      .expired (expired[c])
    );
    assign running[c] = |counter[slice_lo(c, COUNTER_WIDTH) +: COUNTER_WIDTH];
  end
  assign any_running = |running;
endmodule
